// File: rtl/mult_bus_pkg.sv
`timescale 1ns/1ps
// Shared constants for the multiplier bus: func encodings and host FSM states.
package mult_bus_pkg;

  localparam logic [1:0] FUNC_WR_M  = 2'b00;
  localparam logic [1:0] FUNC_WR_Q  = 2'b01;
  localparam logic [1:0] FUNC_RD_LO = 2'b10;
  localparam logic [1:0] FUNC_RD_HI = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_M, ST_TURN1, ST_WR_Q, ST_TURN2, ST_START_HI,
    ST_START_LO, ST_WAIT_RDY, ST_RD_LO, ST_RD_TURN, ST_RD_HI, ST_FIN
  } state_t;

endpackage

// File: rtl/mult_bus_host_if.sv
`timescale 1ns/1ps
// Local request/result signals plus the multiplier control pins (data stays a plain inout).
interface mult_bus_host_if #(parameter int unsigned N = 8);
  logic           req;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic           error;
  logic [2*N-1:0] product;
  logic [1:0]     func;
  logic           oe;
  logic           start;
  logic           ready;

  modport master (input  req, a, b, ready,
                  output busy, done, error, product, func, oe, start);
  modport slave  (output req, a, b, ready,
                  input  busy, done, error, product, func, oe, start);
endinterface

// File: rtl/mult_bus_host_sync2.sv
`timescale 1ns/1ps
// Two-flop synchroniser for a single asynchronous level.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/mult_bus_host.sv
`timescale 1ns/1ps
// Host controller: writes M and Q over the shared bus, pulses start, waits for ready,
// reads both product halves back and returns the 2n-bit result.
module mult_bus_host
    import mult_bus_pkg::*;
#(
    parameter int unsigned n          = 8,
    parameter int unsigned HOLD       = 4,
    parameter int unsigned START_HOLD = 25000,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic            clock,
    input  logic            reset,
    mult_bus_host_if.master bus,
    inout  wire [n-1:0]     data
);
    localparam int unsigned CNT_MAX = (START_HOLD > HOLD) ? START_HOLD : HOLD;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned WW      = $clog2(TIMEOUT + 1);

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [WW-1:0]  r_wdog;
    logic [n-1:0]   r_a;
    logic [n-1:0]   r_b;
    logic [2*n-1:0] r_product;
    logic           r_error;

    logic           w_ready_s;
    logic           w_cnt_hold;
    logic           w_cnt_start;
    logic           w_wd_active;
    logic           w_timeout;
    logic           w_drive;
    logic [n-1:0]   w_dout;
    logic [1:0]     w_func;
    logic           w_oe;
    logic           w_start;

    sync2 u_ready_sync (
        .i_clk (clock),
        .i_rst (reset),
        .i_d   (bus.ready),
        .o_q   (w_ready_s)
    );

    assign w_cnt_hold  = (r_cnt == CW'(HOLD - 1));
    assign w_cnt_start = (r_cnt == CW'(START_HOLD - 1));
    assign w_wd_active = (r_state == ST_START_HI) || (r_state == ST_START_LO) ||
                         (r_state == ST_WAIT_RDY);
    assign w_timeout   = w_wd_active && (r_wdog == WW'(TIMEOUT - 1));

    // Turnaround states already present the next func with the bus released.
    always_comb begin
        w_next  = r_state;
        w_func  = FUNC_RD_LO;
        w_oe    = 1'b0;
        w_start = 1'b0;
        w_drive = 1'b0;
        w_dout  = '0;
        case (r_state)
            ST_IDLE:     if (bus.req) w_next = ST_WR_M;
            ST_WR_M: begin
                w_func  = FUNC_WR_M;
                w_drive = 1'b1;
                w_dout  = r_a;
                if (w_cnt_hold) w_next = ST_TURN1;
            end
            ST_TURN1: begin
                w_func = FUNC_WR_Q;
                w_next = ST_WR_Q;
            end
            ST_WR_Q: begin
                w_func  = FUNC_WR_Q;
                w_drive = 1'b1;
                w_dout  = r_b;
                if (w_cnt_hold) w_next = ST_TURN2;
            end
            ST_TURN2:    w_next = ST_START_HI;
            ST_START_HI: begin
                w_start = 1'b1;
                if (w_cnt_start) w_next = ST_START_LO;
            end
            ST_START_LO: if (w_cnt_start) w_next = ST_WAIT_RDY;
            ST_WAIT_RDY: if (w_ready_s) w_next = ST_RD_LO;
            ST_RD_LO: begin
                w_oe = 1'b1;
                if (w_cnt_hold) w_next = ST_RD_TURN;
            end
            ST_RD_TURN: begin
                w_func = FUNC_RD_HI;
                w_next = ST_RD_HI;
            end
            ST_RD_HI: begin
                w_func = FUNC_RD_HI;
                w_oe   = 1'b1;
                if (w_cnt_hold) w_next = ST_FIN;
            end
            ST_FIN:      w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wdog    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_error <= w_timeout;

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state != ST_IDLE && r_state != ST_WAIT_RDY) begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Watchdog starts at zero on the first START_HI cycle.
            if (r_state == ST_TURN2) begin
                r_wdog <= '0;
            end else if (w_wd_active) begin
                r_wdog <= r_wdog + WW'(1);
            end

            if (r_state == ST_IDLE && bus.req) begin
                r_a <= bus.a;
                r_b <= bus.b;
            end

            if (r_state == ST_RD_LO && w_cnt_hold) begin
                r_product[n-1:0] <= data;
            end
            if (r_state == ST_RD_HI && w_cnt_hold) begin
                r_product[2*n-1:n] <= data;
            end
        end
    end

    assign bus.func    = w_func;
    assign bus.oe      = w_oe;
    assign bus.start   = w_start;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_FIN);
    assign bus.error   = r_error;
    assign bus.product = r_product;
    assign data        = w_drive ? w_dout : 'z;
endmodule

// File: tb/tb_mult_bus_host.sv
`timescale 1ns/1ps
// Bench for mult_bus_host: behavioural multiplier on its own clock, table + random + corner sequences.
module tb_mult_bus_host;
    import mult_bus_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned HLD = 4;
    localparam int unsigned SH  = 8;
    localparam int unsigned TO  = 200;

    logic clock = 1'b0;
    logic mclk  = 1'b0;
    logic reset = 1'b1;
    wire [N-1:0] data;

    mult_bus_host_if #(.N(N)) bus ();

    mult_bus_host #(.n(N), .HOLD(HLD), .START_HOLD(SH), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .data  (data)
    );

    always #5   clock = ~clock;
    always #3.5 mclk  = ~mclk;

    // Multiplier model: latches operands while func selects a write, product is M*Q,
    // ready drops for 20 of its cycles once start has been seen high for 5 cycles.
    typedef enum int {M_NORMAL, M_STUCK1, M_STUCK0} mode_t;
    mode_t        mode = M_NORMAL;
    logic [N-1:0] m_m = '0;
    logic [N-1:0] m_q = '0;
    int unsigned  m_hi_cnt = 0;
    int unsigned  m_low_cnt = 0;
    logic [15:0]  m_p;

    assign m_p = {8'h00, m_m} * {8'h00, m_q};

    always @(posedge mclk) begin
        if (bus.func == FUNC_WR_M) m_m <= data;
        if (bus.func == FUNC_WR_Q) m_q <= data;
        if (bus.start) m_hi_cnt <= m_hi_cnt + 1;
        else           m_hi_cnt <= 0;
        if (m_hi_cnt == 4)       m_low_cnt <= 20;
        else if (m_low_cnt != 0) m_low_cnt <= m_low_cnt - 1;
    end

    assign bus.ready = (mode == M_STUCK1) ? 1'b1 :
                       (mode == M_STUCK0) ? 1'b0 : (m_low_cnt == 0);
    assign data = bus.oe ? ((bus.func == FUNC_RD_HI) ? m_p[15:8] : m_p[7:0]) : 'z;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Bus-ownership checker: the model drives only with oe, the host only on write codes.
    always @(negedge clock) begin
        if (!reset) begin
            n_checks++;
            if (bus.oe && !bus.func[1]) begin
                n_errors++;
                $display("FAIL bus_conflict oe=%b func=%b required no oe on write codes", bus.oe, bus.func);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return bus.done;
            1:       return bus.busy;
            2:       return bus.start;
            default: return bus.oe && (bus.func == FUNC_RD_LO);
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        for (int k = 0; k < 3000 && !cond(sel); k++) @(negedge clock);
        n_checks++;
        if (!cond(sel)) begin
            n_errors++;
            $display("FAIL %s got=timeout exp=event", name);
        end
    endtask

    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_);
        @(negedge clock);
        bus.a   = ta;
        bus.b   = tb_;
        bus.req = 1'b1;
        @(negedge clock);
        bus.req = 1'b0;
        bus.a   = ~ta;
        bus.b   = tb_ ^ 8'h5A;
    endtask

    logic [15:0] t_prod;
    bit          t_done, t_err;
    int          t_lat;
    logic [1:0]  t_efunc;
    logic        t_eoe, t_estart, t_ebusy;
    logic [1:0]  fseq[$];

    task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_);
        int t0;
        launch(ta, tb_);
        check("busy_accepted", bus.busy, 1);
        t_done = 0; t_err = 0; t0 = -1; t_lat = -1; t_prod = 'x;
        fseq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (fseq.size() == 0 || fseq[fseq.size()-1] != bus.func) fseq.push_back(bus.func);
            if (bus.start && t0 < 0) t0 = cyc;
            if (bus.done) begin
                t_done = 1; t_prod = bus.product;
                break;
            end
            if (bus.error) begin
                t_err = 1; t_lat = cyc - t0; t_prod = bus.product;
                t_efunc = bus.func; t_eoe = bus.oe; t_estart = bus.start; t_ebusy = bus.busy;
                break;
            end
            @(negedge clock);
        end
        n_checks++;
        if (!t_done && !t_err) begin
            n_errors++;
            $display("FAIL txn_end got=none exp=done_or_error");
        end
        @(negedge clock);
        check("done_width", bus.done, 0);
        check("error_width", bus.error, 0);
        check("busy_idle", bus.busy, 0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        mode_t       mode;
        logic [15:0] exp_p;
        bit          exp_err;
    } vec_t;

    vec_t       vecs[7];
    logic [1:0] exp_fseq[5];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0;
        bus.a   = '0;
        bus.b   = '0;

        vecs[0] = '{8'd13,  8'd11,  M_NORMAL, 16'h008F, 1'b0};
        vecs[1] = '{8'd255, 8'd255, M_NORMAL, 16'hFE01, 1'b0};
        vecs[2] = '{8'd7,   8'd6,   M_STUCK1, 16'h002A, 1'b0};
        vecs[3] = '{8'd9,   8'd9,   M_STUCK0, 16'h002A, 1'b1};
        vecs[4] = '{8'd0,   8'd200, M_NORMAL, 16'h0000, 1'b0};
        vecs[5] = '{8'd128, 8'd2,   M_NORMAL, 16'h0100, 1'b0};
        vecs[6] = '{8'd1,   8'd255, M_STUCK1, 16'h00FF, 1'b0};
        exp_fseq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};

        repeat (3) @(negedge clock);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_product", bus.product, 0);
        check("rst_func", bus.func, 2'b10);
        check("rst_oe", bus.oe, 0);
        check("rst_start", bus.start, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].mode;
            run_txn(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_product", i), t_prod, vecs[i].exp_p);
            check($sformatf("v%0d_done", i), t_done, !vecs[i].exp_err);
            check($sformatf("v%0d_error", i), t_err, vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_err_latency", i), t_lat, TO);
                check($sformatf("v%0d_err_func", i), t_efunc, 2'b10);
                check($sformatf("v%0d_err_oe", i), t_eoe, 0);
                check($sformatf("v%0d_err_start", i), t_estart, 0);
                check($sformatf("v%0d_err_busy", i), t_ebusy, 0);
            end else begin
                check($sformatf("v%0d_fseq_len", i), fseq.size(), 5);
                if (fseq.size() == 5)
                    for (int j = 0; j < 5; j++)
                        check($sformatf("v%0d_fseq%0d", i, j), fseq[j], exp_fseq[j]);
            end
        end
        mode = M_NORMAL;

        for (int i = 0; i < 8; i++) begin
            logic [7:0]  ra, rb;
            logic [15:0] e;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            e  = 16'(int'(ra) * int'(rb));
            run_txn(ra, rb);
            check($sformatf("rnd%0d_done", i), t_done, 1);
            check($sformatf("rnd%0d_product", i), t_prod, e);
        end

        // Reset while start is high.
        launch(8'd50, 8'd60);
        wait_for(2, "wait_start_hi");
        reset = 1'b1;
        #1;
        check("rst1_busy", bus.busy, 0);
        check("rst1_start", bus.start, 0);
        check("rst1_func", bus.func, 2'b10);
        check("rst1_oe", bus.oe, 0);
        check("rst1_product", bus.product, 0);
        @(negedge clock);
        reset = 1'b0;

        // Reset while reading the low half.
        launch(8'd70, 8'd80);
        wait_for(3, "wait_rd_lo");
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst2_oe", bus.oe, 0);
        check("rst2_func", bus.func, 2'b10);
        check("rst2_busy", bus.busy, 0);
        check("rst2_done", bus.done, 0);
        check("rst2_product", bus.product, 0);
        @(negedge clock);
        reset = 1'b0;
        run_txn(8'd3, 8'd5);
        check("post_rst_product", t_prod, 16'h000F);

        // req held high: back-to-back, operands fixed at acceptance.
        @(negedge clock);
        bus.a = 8'd20; bus.b = 8'd30; bus.req = 1'b1;
        wait_for(1, "b2b_busy1");
        bus.a = 8'd40; bus.b = 8'd50;
        wait_for(0, "b2b_done1");
        check("b2b_product1", bus.product, 16'd600);
        @(negedge clock);
        check("b2b_idle_gap", bus.busy, 0);
        @(negedge clock);
        check("b2b_accept2", bus.busy, 1);
        check("b2b_func2", bus.func, 2'b00);
        bus.a = 8'd1; bus.b = 8'd2; bus.req = 1'b0;
        wait_for(0, "b2b_done2");
        check("b2b_product2", bus.product, 16'd2000);
        @(negedge clock);
        check("b2b_end_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
